// File: rtl/eq_gain_ramper_if.sv
// Port bundle for eq_gain_ramper: CPU target writes, frame strobe, and the gain RAM write port.
interface eq_gain_ramper_if;
  logic        run;
  logic        cpu_wr;
  logic [3:0]  cpu_sel;
  logic [15:0] cpu_gain;
  logic        frame_stb;
  logic        eq_wr;
  logic [3:0]  eq_wr_sel;
  logic [7:0]  eq_gain_lsb;
  logic [7:0]  eq_gain_msb;
  logic        busy;
  logic        settled;

  modport master (
    output run, cpu_wr, cpu_sel, cpu_gain, frame_stb,
    input  eq_wr, eq_wr_sel, eq_gain_lsb, eq_gain_msb, busy, settled
  );

  modport slave (
    input  run, cpu_wr, cpu_sel, cpu_gain, frame_stb,
    output eq_wr, eq_wr_sel, eq_gain_lsb, eq_gain_msb, busy, settled
  );
endinterface

// File: rtl/eq_gain_ramper.sv
// Ramps each live eq gain toward its CPU target by at most STEP per frame, one filter per cycle.
// Optional EQ_RAMP_SNAP_EN: with run low, CPU writes go straight to live gain and the RAM.
module eq_gain_ramper #(
  parameter int unsigned num_of_filters = 4,
  parameter logic [15:0] STEP           = 16'd64
) (
  input logic             clk,
  input logic             reset,
  eq_gain_ramper_if.slave bus
);

  localparam int unsigned IdxW = (num_of_filters > 1) ? $clog2(num_of_filters) : 1;
  localparam logic [3:0] LastIdx = 4'(num_of_filters - 1);
  localparam logic signed [16:0] StepPos = {1'b0, STEP};
  localparam logic signed [16:0] StepNeg = -StepPos;

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic signed [15:0] target_q [num_of_filters];
  logic signed [15:0] target_d [num_of_filters];
  logic signed [15:0] live_q   [num_of_filters];
  logic signed [15:0] live_d   [num_of_filters];
  logic               eq_wr_q, eq_wr_d;
  logic [3:0]         eq_wr_sel_q, eq_wr_sel_d;
  logic [15:0]        eq_gain_q, eq_gain_d;

  logic [IdxW-1:0]    scan_idx, cpu_idx;
  logic               cpu_hit;
  logic signed [15:0] cur_t, cur_l, new_gain;
  logic signed [16:0] diff;

  assign scan_idx = idx_q[IdxW-1:0];
  assign cpu_idx  = bus.cpu_sel[IdxW-1:0];
  assign cpu_hit  = bus.cpu_wr && (32'(bus.cpu_sel) < num_of_filters);
  assign cur_t    = target_q[scan_idx];
  assign cur_l    = live_q[scan_idx];
  // Sign-extend to 17 bits so the difference of two in-range gains cannot wrap.
  assign diff     = {cur_t[15], cur_t} - {cur_l[15], cur_l};

  always_comb begin
    if (diff > StepPos) begin
      new_gain = cur_l + $signed(STEP);
    end else if (diff < StepNeg) begin
      new_gain = cur_l - $signed(STEP);
    end else begin
      new_gain = cur_t;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    target_d    = target_q;
    live_d      = live_q;
    eq_wr_d     = 1'b0;
    eq_wr_sel_d = eq_wr_sel_q;
    eq_gain_d   = eq_gain_q;

    if (cpu_hit) begin
      target_d[cpu_idx] = bus.cpu_gain;
`ifdef EQ_RAMP_SNAP_EN
      if (!bus.run) begin
        live_d[cpu_idx] = bus.cpu_gain;
        eq_wr_d         = 1'b1;
        eq_wr_sel_d     = bus.cpu_sel;
        eq_gain_d       = bus.cpu_gain;
      end
`endif
    end

    unique case (state_q)
      StIdle: begin
        if (bus.frame_stb && bus.run) begin
          state_d = StScan;
          idx_d   = '0;
        end
      end
      StScan: begin
        if (!bus.run) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          if (new_gain != cur_l) begin
            live_d[scan_idx] = new_gain;
            eq_wr_d          = 1'b1;
            eq_wr_sel_d      = idx_q;
            eq_gain_d        = new_gain;
          end
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      eq_wr_q     <= 1'b0;
      eq_wr_sel_q <= '0;
      eq_gain_q   <= '0;
      for (int i = 0; i < int'(num_of_filters); i++) begin
        target_q[i] <= '0;
        live_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      eq_wr_q     <= eq_wr_d;
      eq_wr_sel_q <= eq_wr_sel_d;
      eq_gain_q   <= eq_gain_d;
      target_q    <= target_d;
      live_q      <= live_d;
    end
  end

  always_comb begin
    bus.settled = 1'b1;
    for (int i = 0; i < int'(num_of_filters); i++) begin
      if (live_q[i] != target_q[i]) begin
        bus.settled = 1'b0;
      end
    end
  end

  assign bus.eq_wr       = eq_wr_q;
  assign bus.eq_wr_sel   = eq_wr_sel_q;
  assign bus.eq_gain_lsb = eq_gain_q[7:0];
  assign bus.eq_gain_msb = eq_gain_q[15:8];
  assign bus.busy        = (state_q == StScan);

endmodule

// File: tb/tb_eq_gain_ramper.sv
// Directed bench for eq_gain_ramper (4 filters, STEP=64); inputs driven and outputs sampled at negedge.
module tb_eq_gain_ramper;
  localparam int unsigned NF = 4;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  eq_gain_ramper_if bus ();

  eq_gain_ramper #(
    .num_of_filters(NF),
    .STEP          (16'd64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [3:0] sel, input logic [15:0] gain);
    bus.cpu_wr   = 1'b1;
    bus.cpu_sel  = sel;
    bus.cpu_gain = gain;
    tick();
    bus.cpu_wr   = 1'b0;
  endtask

  // Strobe one frame, then watch NF+1 edges and report the writes seen.
  task automatic run_frame(output int nwr, output logic [3:0] lsel, output logic [15:0] lgain);
    nwr   = 0;
    lsel  = '0;
    lgain = '0;
    bus.frame_stb = 1'b1;
    tick();
    bus.frame_stb = 1'b0;
    repeat (NF + 1) begin
      tick();
      if (bus.eq_wr === 1'b1) begin
        nwr++;
        lsel  = bus.eq_wr_sel;
        lgain = {bus.eq_gain_msb, bus.eq_gain_lsb};
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.eq_wr, bus.eq_wr_sel, bus.eq_gain_msb, bus.eq_gain_lsb} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%b sel=%0d gain=%h, want all 0", bus.eq_wr,
               bus.eq_wr_sel, {bus.eq_gain_msb, bus.eq_gain_lsb});
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.settled !== 1'b1) begin
      errors++;
      $display("FAIL reset_status: got busy=%b settled=%b, want busy=0 settled=1", bus.busy,
               bus.settled);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ramp_up();
    logic [15:0] exp_gain [4] = '{16'h0040, 16'h0080, 16'h00C0, 16'h0100};
    int          nwr;
    logic [3:0]  lsel;
    logic [15:0] lgain;
    bus.run = 1'b1;
    cpu_write(4'd2, 16'h0100);
    for (int f = 1; f <= 5; f++) begin
      run_frame(nwr, lsel, lgain);
      checks++;
      if (nwr !== ((f <= 4) ? 1 : 0)) begin
        errors++;
        $display("FAIL up_count f%0d: got %0d writes, want %0d", f, nwr, (f <= 4) ? 1 : 0);
      end
      if (f <= 4) begin
        checks++;
        if (lsel !== 4'd2 || lgain !== exp_gain[f-1]) begin
          errors++;
          $display("FAIL up_write f%0d: got sel=%0d gain=%h, want sel=2 gain=%h", f, lsel, lgain,
                   exp_gain[f-1]);
        end
      end
      checks++;
      if (bus.settled !== (f >= 4)) begin
        errors++;
        $display("FAIL up_settled f%0d: got %b, want %b", f, bus.settled, f >= 4);
      end
    end
  endtask

  task automatic test_ramp_down();
    logic [15:0] exp_gain [2] = '{16'hFFC0, 16'hFFA0};
    int          nwr;
    logic [3:0]  lsel;
    logic [15:0] lgain;
    cpu_write(4'd0, 16'hFFA0);
    for (int f = 1; f <= 3; f++) begin
      run_frame(nwr, lsel, lgain);
      checks++;
      if (nwr !== ((f <= 2) ? 1 : 0)) begin
        errors++;
        $display("FAIL down_count f%0d: got %0d writes, want %0d", f, nwr, (f <= 2) ? 1 : 0);
      end
      if (f <= 2) begin
        checks++;
        if (lsel !== 4'd0 || lgain !== exp_gain[f-1]) begin
          errors++;
          $display("FAIL down_write f%0d: got sel=%0d gain=%h, want sel=0 gain=%h", f, lsel,
                   lgain, exp_gain[f-1]);
        end
      end
    end
  endtask

  task automatic test_latency();
    // Indexed by edge number after the frame strobe edge E0.
    logic        exp_wr   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        exp_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0]  exp_sel  [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd3};
    logic [15:0] exp_gn   [6] = '{16'h0, 16'hFFB0, 16'h0, 16'h0, 16'h0020, 16'h0};
    cpu_write(4'd0, 16'hFFB0);
    cpu_write(4'd3, 16'h0020);
    bus.frame_stb = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      bus.frame_stb = 1'b0;
      checks++;
      if (bus.eq_wr !== exp_wr[e] || bus.busy !== exp_busy[e]) begin
        errors++;
        $display("FAIL latency E%0d: got wr=%b busy=%b, want wr=%b busy=%b", e, bus.eq_wr,
                 bus.busy, exp_wr[e], exp_busy[e]);
      end
      if (exp_wr[e]) begin
        checks++;
        if (bus.eq_wr_sel !== exp_sel[e] || {bus.eq_gain_msb, bus.eq_gain_lsb} !== exp_gn[e]) begin
          errors++;
          $display("FAIL latency_data E%0d: got sel=%0d gain=%h, want sel=%0d gain=%h", e,
                   bus.eq_wr_sel, {bus.eq_gain_msb, bus.eq_gain_lsb}, exp_sel[e], exp_gn[e]);
        end
      end
    end
  endtask

  task automatic test_interference();
    int nwr;
    int nbusy;
    cpu_write(4'd0, 16'hFFF0);
    cpu_write(4'd1, 16'h0400);
    cpu_write(4'd2, 16'h0400);
    cpu_write(4'd3, 16'h0400);
    bus.frame_stb = 1'b1;
    tick();
    bus.frame_stb = 1'b0;
    tick();
    checks++;
    if (bus.eq_wr !== 1'b1 || bus.eq_wr_sel !== 4'd0) begin
      errors++;
      $display("FAIL abort_first: got wr=%b sel=%0d, want wr=1 sel=0", bus.eq_wr, bus.eq_wr_sel);
    end
    bus.run       = 1'b0;
    bus.frame_stb = 1'b1;
    tick();
    bus.frame_stb = 1'b0;
    checks++;
    if (bus.eq_wr !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got wr=%b busy=%b, want wr=0 busy=0", bus.eq_wr, bus.busy);
    end
    nwr = 0;
    repeat (3) begin
      tick();
      if (bus.eq_wr === 1'b1 || bus.busy === 1'b1) nwr++;
    end
    checks++;
    if (nwr !== 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles, want 0", nwr);
    end

    bus.run       = 1'b1;
    bus.frame_stb = 1'b1;
    tick();
    bus.frame_stb = 1'b0;
    tick();
    bus.frame_stb = 1'b1;
    nwr   = 0;
    nbusy = 0;
    repeat (7) begin
      tick();
      bus.frame_stb = 1'b0;
      if (bus.eq_wr === 1'b1) nwr++;
      if (bus.busy === 1'b1) nbusy++;
    end
    checks++;
    if (nwr !== 3 || nbusy !== 2) begin
      errors++;
      $display("FAIL restrobe: got writes=%0d busy_cycles=%0d, want writes=3 busy_cycles=2", nwr,
               nbusy);
    end
  endtask

  task automatic test_reset_mid();
    int          nwr;
    logic [3:0]  lsel;
    logic [15:0] lgain;
    bus.frame_stb = 1'b1;
    tick();
    bus.frame_stb = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.eq_wr !== 1'b1 || {bus.eq_gain_msb, bus.eq_gain_lsb} !== 16'h0080) begin
      errors++;
      $display("FAIL mid_pre: got wr=%b gain=%h, want wr=1 gain=0080", bus.eq_wr,
               {bus.eq_gain_msb, bus.eq_gain_lsb});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.eq_wr, bus.eq_wr_sel, bus.eq_gain_msb, bus.eq_gain_lsb} !== 21'd0 ||
        bus.busy !== 1'b0 || bus.settled !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got wr=%b sel=%0d gain=%h busy=%b settled=%b, want 0/0/0000/0/1",
               bus.eq_wr, bus.eq_wr_sel, {bus.eq_gain_msb, bus.eq_gain_lsb}, bus.busy,
               bus.settled);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    cpu_write(4'd5, 16'h7FFF);
    checks++;
    if (bus.settled !== 1'b1) begin
      errors++;
      $display("FAIL bad_sel_settled: got %b, want 1", bus.settled);
    end
    run_frame(nwr, lsel, lgain);
    checks++;
    if (nwr !== 0) begin
      errors++;
      $display("FAIL bad_sel_writes: got %0d writes (sel=%0d gain=%h), want 0", nwr, lsel, lgain);
    end
  endtask

  task automatic test_snap();
    bus.run = 1'b0;
    cpu_write(4'd1, 16'h1234);
`ifdef EQ_RAMP_SNAP_EN
    checks++;
    if (bus.eq_wr !== 1'b1 || bus.eq_wr_sel !== 4'd1 || bus.eq_gain_lsb !== 8'h34 ||
        bus.eq_gain_msb !== 8'h12 || bus.settled !== 1'b1) begin
      errors++;
      $display("FAIL snap: got wr=%b sel=%0d lsb=%h msb=%h settled=%b, want 1/1/34/12/1",
               bus.eq_wr, bus.eq_wr_sel, bus.eq_gain_lsb, bus.eq_gain_msb, bus.settled);
    end
    tick();
    checks++;
    if (bus.eq_wr !== 1'b0) begin
      errors++;
      $display("FAIL snap_pulse: got wr=%b, want 0", bus.eq_wr);
    end
`else
    checks++;
    if (bus.eq_wr !== 1'b0 || bus.settled !== 1'b0) begin
      errors++;
      $display("FAIL no_snap: got wr=%b settled=%b, want wr=0 settled=0", bus.eq_wr,
               bus.settled);
    end
    tick();
    checks++;
    if (bus.eq_wr !== 1'b0 || {bus.eq_gain_msb, bus.eq_gain_lsb} !== 16'h0000) begin
      errors++;
      $display("FAIL no_snap_hold: got wr=%b gain=%h, want wr=0 gain=0000", bus.eq_wr,
               {bus.eq_gain_msb, bus.eq_gain_lsb});
    end
`endif
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    bus.run       = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_sel   = '0;
    bus.cpu_gain  = '0;
    bus.frame_stb = 1'b0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_latency();
    test_interference();
    test_reset_mid();
    test_snap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
